// File: rtl/univ_mod_counter_amisha.sv
// rtl/univ_mod_counter_amisha.sv - W-bit up/down counter with runtime top value, step and wrap/saturate mode
//
// Optional feature macro: UCNT_CMP_EN (adds cmp_amisha / match_amisha compare pulse).
//
// Ports:
//   clk_amisha      in   1       clock, all state on rising edge
//   reset_n_amisha  in   1       synchronous reset, active low
//   syn_clr_amisha  in   1       synchronous clear to 0
//   load_amisha     in   1       synchronous load of d_amisha (clamped to mod)
//   en_amisha       in   1       count enable
//   up_amisha       in   1       1 = count up, 0 = count down
//   sat_amisha      in   1       1 = saturate at bounds, 0 = wrap
//   step_amisha     in   STEP_W  increment per enabled cycle, 0 = hold
//   mod_amisha      in   W       top value, legal count range 0..mod
//   d_amisha        in   W       load value
//   cmp_amisha      in   W       compare value (UCNT_CMP_EN only)
//   q_amisha        out  W       registered count
//   max_tick_amisha out  1       q == mod
//   min_tick_amisha out  1       q == 0
//   wrap_amisha     out  1       registered pulse, high in the cycle q shows a post-wrap value
//   match_amisha    out  1       registered pulse on first cycle q equals cmp (UCNT_CMP_EN only)

module univ_mod_counter_amisha #(
    parameter int W      = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk_amisha,
    input  logic              reset_n_amisha,
    input  logic              syn_clr_amisha,
    input  logic              load_amisha,
    input  logic              en_amisha,
    input  logic              up_amisha,
    input  logic              sat_amisha,
    input  logic [STEP_W-1:0] step_amisha,
    input  logic [W-1:0]      mod_amisha,
    input  logic [W-1:0]      d_amisha,
`ifdef UCNT_CMP_EN
    input  logic [W-1:0]      cmp_amisha,
    output logic              match_amisha,
`endif
    output logic [W-1:0]      q_amisha,
    output logic              max_tick_amisha,
    output logic              min_tick_amisha,
    output logic              wrap_amisha
);

    // Arithmetic width: one bit wider than the wider operand so the sum never truncates
    // and the borrow of a subtraction is visible.
    localparam int CW = ((W > STEP_W) ? W : STEP_W) + 1;

    logic [CW-1:0] q_ext;
    logic [CW-1:0] step_ext;
    logic [CW-1:0] mod_ext;
    logic [CW-1:0] sum;
    logic [CW-1:0] diff;
    logic [W-1:0]  q_next;
    logic          wrap_next;

    assign q_ext    = CW'(q_amisha);
    assign step_ext = CW'(step_amisha);
    assign mod_ext  = CW'(mod_amisha);
    assign sum      = q_ext + step_ext;
    assign diff     = q_ext - step_ext;

    always_comb begin
        q_next    = q_amisha;
        wrap_next = 1'b0;
        if (syn_clr_amisha) begin
            q_next = '0;
        end else if (load_amisha) begin
            q_next = (d_amisha > mod_amisha) ? mod_amisha : d_amisha;
        end else if (en_amisha && (step_amisha != '0)) begin
            if (q_amisha > mod_amisha) begin
                // mod was lowered below the current count: pull back to the top value
                q_next = mod_amisha;
            end else if (up_amisha) begin
                if (sum <= mod_ext) begin
                    q_next = W'(sum);
                end else if (sat_amisha) begin
                    q_next = mod_amisha;
                end else begin
                    // overshoot beyond the bound is discarded, not carried as a remainder
                    q_next    = '0;
                    wrap_next = 1'b1;
                end
            end else begin
                if (q_ext >= step_ext) begin
                    q_next = W'(diff);
                end else if (sat_amisha) begin
                    q_next = '0;
                end else begin
                    q_next    = mod_amisha;
                    wrap_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_amisha) begin
        if (!reset_n_amisha) begin
            q_amisha    <= '0;
            wrap_amisha <= 1'b0;
        end else begin
            q_amisha    <= q_next;
            wrap_amisha <= wrap_next;
        end
    end

`ifdef UCNT_CMP_EN
    // Pulses only on arrival at cmp; sitting on cmp keeps it low.
    always_ff @(posedge clk_amisha) begin
        if (!reset_n_amisha) begin
            match_amisha <= 1'b0;
        end else begin
            match_amisha <= (q_next == cmp_amisha) && (q_next != q_amisha);
        end
    end
`endif

    assign max_tick_amisha = (q_amisha == mod_amisha);
    assign min_tick_amisha = (q_amisha == '0);

endmodule

// File: tb/tb_univ_mod_counter_amisha.sv
// tb/tb_univ_mod_counter_amisha.sv - scoreboard bench for univ_mod_counter_amisha

module tb_univ_mod_counter_amisha;

    localparam int W      = 8;
    localparam int STEP_W = 4;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              syn_clr = 1'b0;
    logic              load = 1'b0;
    logic              en = 1'b0;
    logic              up = 1'b1;
    logic              sat = 1'b0;
    logic [STEP_W-1:0] step = '0;
    logic [W-1:0]      mod_v = '0;
    logic [W-1:0]      d = '0;
    logic [W-1:0]      q;
    logic              max_tick;
    logic              min_tick;
    logic              wrap;
`ifdef UCNT_CMP_EN
    logic [W-1:0]      cmp = '0;
    logic              match;
`endif

    univ_mod_counter_amisha #(.W(W), .STEP_W(STEP_W)) dut (
        .clk_amisha      (clk),
        .reset_n_amisha  (reset_n),
        .syn_clr_amisha  (syn_clr),
        .load_amisha     (load),
        .en_amisha       (en),
        .up_amisha       (up),
        .sat_amisha      (sat),
        .step_amisha     (step),
        .mod_amisha      (mod_v),
        .d_amisha        (d),
`ifdef UCNT_CMP_EN
        .cmp_amisha      (cmp),
        .match_amisha    (match),
`endif
        .q_amisha        (q),
        .max_tick_amisha (max_tick),
        .min_tick_amisha (min_tick),
        .wrap_amisha     (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        int q;
        bit wrap;
        bit max_t;
        bit min_t;
        bit match;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mq = 0;        // reference count

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference: next count from the rules, using plain integer arithmetic.
    task automatic model(output exp_t e);
        int nq;
        bit w;
        int m;
        int s;
        m  = int'(mod_v);
        s  = int'(step);
        nq = mq;
        w  = 0;
        if (!reset_n || syn_clr) nq = 0;
        else if (load) nq = (int'(d) > m) ? m : int'(d);
        else if (en && s != 0) begin
            if (mq > m) nq = m;
            else if (up) begin
                if (mq + s <= m) nq = mq + s;
                else if (sat) nq = m;
                else begin nq = 0; w = 1; end
            end else begin
                if (mq - s >= 0) nq = mq - s;
                else if (sat) nq = 0;
                else begin nq = m; w = 1; end
            end
        end
        e.q     = nq;
        e.wrap  = w;
        e.max_t = (nq == m);
        e.min_t = (nq == 0);
`ifdef UCNT_CMP_EN
        e.match = reset_n && (nq == int'(cmp)) && (nq != mq);
`else
        e.match = 0;
`endif
        mq = nq;
    endtask

    // Inputs change at the falling edge; the expectation for the next rising edge is queued.
    task automatic cyc(input bit rn, input bit clr, input bit ld, input bit e_n, input bit u,
                       input bit sa, input int st, input int md, input int dv);
        exp_t e;
        @(negedge clk);
        reset_n = rn; syn_clr = clr; load = ld; en = e_n; up = u; sat = sa;
        step = STEP_W'(st); mod_v = W'(md); d = W'(dv);
        model(e);
        exp_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // Monitor: every rising edge the DUT presents a new count; compare against the queue head.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("q", int'(q), e.q);
            check("wrap", int'(wrap), int'(e.wrap));
            check("max_tick", int'(max_tick), int'(e.max_t));
            check("min_tick", int'(min_tick), int'(e.min_t));
`ifdef UCNT_CMP_EN
            check("match", int'(match), int'(e.match));
`endif
        end
    end

    initial begin
        // 1: reset dominates an enabled count
        cyc(0, 0, 0, 1, 1, 0, 3, 255, 0);
        cyc(0, 0, 0, 1, 1, 0, 3, 255, 0);
        check("t1 reset q", int'(q), 0);
        check("t1 reset min_tick", int'(min_tick), 1);
        cyc(1, 0, 0, 1, 1, 0, 3, 255, 0);
        check("t1 release q", int'(q), 3);

        // 2: mod 9, step 1, wrap
        cyc(1, 1, 0, 0, 1, 0, 1, 9, 0);
        for (int i = 0; i < 10; i++) begin
            cyc(1, 0, 0, 1, 1, 0, 1, 9, 0);
            check("t2 q", int'(q), (i + 1) % 10);
            check("t2 wrap", int'(wrap), (i == 9) ? 1 : 0);
            check("t2 max_tick", int'(max_tick), (i == 8) ? 1 : 0);
        end

        // 3: saturate up with overshoot
        cyc(1, 0, 1, 0, 1, 1, 7, 200, 195);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 1, 1, 1, 7, 200, 0);
            check("t3 q", int'(q), 200);
            check("t3 wrap", int'(wrap), 0);
            check("t3 max_tick", int'(max_tick), 1);
        end

        // 4: down wrap goes to mod
        cyc(1, 0, 1, 0, 0, 0, 4, 50, 3);
        cyc(1, 0, 0, 1, 0, 0, 4, 50, 0);
        check("t4 q wrap", int'(q), 50);
        check("t4 wrap", int'(wrap), 1);
        cyc(1, 0, 0, 1, 0, 0, 4, 50, 0);
        check("t4 q next", int'(q), 46);
        check("t4 wrap next", int'(wrap), 0);

        // 5: clear priority, clamped load, lowered mod
        cyc(1, 1, 1, 1, 1, 0, 1, 100, 77);
        check("t5 clr q", int'(q), 0);
        cyc(1, 0, 1, 0, 1, 0, 1, 100, 250);
        check("t5 load clamp", int'(q), 100);
        cyc(1, 0, 0, 1, 1, 0, 1, 60, 0);
        check("t5 lowered mod q", int'(q), 60);
        check("t5 lowered mod wrap", int'(wrap), 0);

        // mod = 0 in wrap mode pulses wrap every cycle
        cyc(1, 0, 0, 1, 1, 0, 2, 0, 0);
        cyc(1, 0, 0, 1, 1, 0, 2, 0, 0);
        check("mod0 q", int'(q), 0);
        check("mod0 wrap", int'(wrap), 1);

`ifdef UCNT_CMP_EN
        // 6: compare pulse
        cmp = 8'd5;
        cyc(1, 1, 0, 0, 1, 0, 1, 100, 0);
        for (int i = 1; i <= 6; i++) begin
            cyc(1, 0, 0, 1, 1, 0, 1, 100, 0);
            check("t6 match", int'(match), (i == 5) ? 1 : 0);
        end
        cyc(1, 0, 1, 0, 1, 0, 1, 100, 5);
        cyc(1, 0, 0, 0, 1, 0, 1, 100, 0);
        check("t6 hold match", int'(match), 0);
`endif

        // Randomized run against the reference model
        for (int i = 0; i < 3000; i++) begin
            int md;
            md = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 12) : $urandom_range(0, 255);
`ifdef UCNT_CMP_EN
            if ($urandom_range(0, 15) == 0) cmp = W'($urandom_range(0, 255));
`endif
            cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 4) != 0),
                $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, 15), md, $urandom_range(0, 255));
        end

        @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
